// File: rtl/rx_serial_receiver.sv
// ---------------------------------------------------------------------------
// rx_serial_receiver
//
// 8N1 asynchronous serial receiver with an optional even-parity bit.
// The serial line is synchronised into the clock domain. The start bit is
// checked at its midpoint. Every following bit is then sampled one bit
// period apart, so each sample lands near the middle of its bit.
//
// Optional feature: define RX_PARITY_EN to insert one even-parity bit
// between the data bits and the stop bit. This also adds the parity_error
// port.
//
// Parameters
//   CLKS_PER_BIT   clock cycles per serial bit (4..65535)
//
// Ports
//   clk            system clock, rising-edge active
//   reset          asynchronous active-low reset
//   rx_in          serial line, idle high, asynchronous to clk
//   data_out       last correctly received byte
//   data_valid     one-cycle pulse when data_out is updated
//   framing_error  one-cycle pulse when the stop bit samples low
//   parity_error   one-cycle pulse on parity mismatch (RX_PARITY_EN only)
//   rx_busy        high while the receiver is not idle
// ---------------------------------------------------------------------------
module rx_serial_receiver #(
  parameter int unsigned CLKS_PER_BIT = 5208
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_in,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       framing_error,
`ifdef RX_PARITY_EN
  output logic       parity_error,
`endif
  output logic       rx_busy
);

  localparam logic [15:0] HALF_END = 16'(CLKS_PER_BIT / 2 - 1);
  localparam logic [15:0] BIT_END  = 16'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef RX_PARITY_EN
    PARITY,
`endif
    STOP,
    WAIT_HIGH
  } state_t;

  logic        sync1_q, sync2_q;
  logic        rx_s;
  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  data_q, data_d;
  logic        valid_q, valid_d;
  logic        ferr_q, ferr_d;
  logic        busy_q, busy_d;
`ifdef RX_PARITY_EN
  logic        perr_q, perr_d;
  logic        pbad_q, pbad_d;
`endif

  assign rx_s = sync2_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
`ifdef RX_PARITY_EN
    perr_d  = 1'b0;
    pbad_d  = pbad_q;
`endif
    case (state_q)
      IDLE: begin
        if (!rx_s) begin
          state_d = START;
          cnt_d   = '0;
        end
      end
      START: begin
        // Re-check the start bit at its midpoint; a high line here is a glitch.
        if (cnt_q == HALF_END) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = rx_s ? IDLE : DATA;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      DATA: begin
        if (cnt_q == BIT_END) begin
          cnt_d   = '0;
          shift_d = {rx_s, shift_q[7:1]};  // LSB arrives first
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
`ifdef RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
`ifdef RX_PARITY_EN
      PARITY: begin
        if (cnt_q == BIT_END) begin
          cnt_d   = '0;
          // Even parity: data ones plus parity bit must be even.
          pbad_d  = (^shift_q) ^ rx_s;
          state_d = STOP;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
`endif
      STOP: begin
        if (cnt_q == BIT_END) begin
          cnt_d = '0;
          if (rx_s) begin
            state_d = IDLE;
`ifdef RX_PARITY_EN
            if (pbad_q) begin
              perr_d = 1'b1;
            end else begin
              data_d  = shift_q;
              valid_d = 1'b1;
            end
`else
            data_d  = shift_q;
            valid_d = 1'b1;
`endif
          end else begin
            // A framing error outranks a parity error; only one pulse fires.
            ferr_d  = 1'b1;
            state_d = WAIT_HIGH;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      WAIT_HIGH: begin
        // Break condition: the line must go idle before a new start bit counts.
        if (rx_s) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      busy_q  <= 1'b0;
`ifdef RX_PARITY_EN
      perr_q  <= 1'b0;
      pbad_q  <= 1'b0;
`endif
    end else begin
      sync1_q <= rx_in;
      sync2_q <= sync1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      busy_q  <= busy_d;
`ifdef RX_PARITY_EN
      perr_q  <= perr_d;
      pbad_q  <= pbad_d;
`endif
    end
  end

  assign data_out      = data_q;
  assign data_valid    = valid_q;
  assign framing_error = ferr_q;
  assign rx_busy       = busy_q;
`ifdef RX_PARITY_EN
  assign parity_error  = perr_q;
`endif

endmodule

// File: tb/tb_rx_serial_receiver.sv
// ---------------------------------------------------------------------------
// tb_rx_serial_receiver
//
// Directed bench for rx_serial_receiver at CLKS_PER_BIT = 16.
// A monitor counts output pulses and records the received bytes.
// It also records pulses that occur together or in consecutive cycles.
// The main sequence drives frames and compares against hand-computed
// values.
// ---------------------------------------------------------------------------
module tb_rx_serial_receiver;

  localparam int CPB = 16;
`ifdef RX_PARITY_EN
  localparam int LAT_NOM = 2 + CPB / 2 + 9 * CPB + CPB;
`else
  localparam int LAT_NOM = 2 + CPB / 2 + 9 * CPB;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       rx_in;
  logic [7:0] data_out;
  logic       data_valid;
  logic       framing_error;
  logic       rx_busy;
  logic       perr_w;

  rx_serial_receiver #(.CLKS_PER_BIT(CPB)) dut (
    .clk           (clk),
    .reset         (reset),
    .rx_in         (rx_in),
    .data_out      (data_out),
    .data_valid    (data_valid),
    .framing_error (framing_error),
`ifdef RX_PARITY_EN
    .parity_error  (perr_w),
`endif
    .rx_busy       (rx_busy)
  );

`ifndef RX_PARITY_EN
  assign perr_w = 1'b0;
`endif

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Pulse monitor, sampled on the falling edge.
  int         dv_cnt = 0, fe_cnt = 0, pe_cnt = 0, viol = 0;
  int         last_dv_cyc = 0;
  logic [7:0] last_data = 8'h00, prev_data = 8'h00;
  logic       prev_any = 1'b0;
  always @(negedge clk) begin
    int n;
    n = int'(data_valid) + int'(framing_error) + int'(perr_w);
    if (n > 1) viol = viol + 1;
    if (n > 0 && prev_any) viol = viol + 1;
    prev_any = (n > 0);
    if (data_valid) begin
      dv_cnt      = dv_cnt + 1;
      last_dv_cyc = cyc;
      prev_data   = last_data;
      last_data   = data_out;
    end
    if (framing_error) fe_cnt = fe_cnt + 1;
    if (perr_w)        pe_cnt = pe_cnt + 1;
  end

  int tests = 0;
  int failed = 0;
  int fall_cyc = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests = tests + 1;
    assert (obs === exp) else begin
      failed = failed + 1;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drives one frame starting at a falling edge. The stop level is held
  // for stop_len cycles and left on the line afterwards.
  task automatic send_frame(input logic [7:0] d, input logic par,
                            input logic stop_v, input int stop_len);
    rx_in    = 1'b0;
    fall_cyc = cyc;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_in = d[i];
      repeat (CPB) @(negedge clk);
    end
`ifdef RX_PARITY_EN
    rx_in = par;
    repeat (CPB) @(negedge clk);
`else
    if (par) rx_in = rx_in;  // no parity bit in this build
`endif
    rx_in = stop_v;
    repeat (stop_len) @(negedge clk);
  endtask

  initial begin
    int dv0, fe0, pe0, lat;
    reset = 1'b0;
    rx_in = 1'b1;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_data_out", 32'(data_out), 32'h00);
    check("rst_data_valid", 32'(data_valid), 32'h0);
    check("rst_framing_error", 32'(framing_error), 32'h0);
    check("rst_rx_busy", 32'(rx_busy), 32'h0);
    reset = 1'b1;
    repeat (10) @(negedge clk);

    // Frame 8'hA5 with a good stop bit
    dv0 = dv_cnt; fe0 = fe_cnt; pe0 = pe_cnt;
    send_frame(8'hA5, ^8'hA5, 1'b1, CPB);
    rx_in = 1'b1;
    repeat (4) @(negedge clk);
    check("a5_data_out", 32'(data_out), 32'hA5);
    check("a5_dv_pulses", 32'(dv_cnt - dv0), 32'd1);
    check("a5_fe_pulses", 32'(fe_cnt - fe0), 32'd0);
    check("a5_busy_after", 32'(rx_busy), 32'h0);
    lat = last_dv_cyc - fall_cyc;
    tests = tests + 1;
    assert (lat >= LAT_NOM - 1 && lat <= LAT_NOM + 1) else begin
      failed = failed + 1;
      $error("FAIL a5_latency: observed %0d expected %0d +/-1", lat, LAT_NOM);
    end

    // Glitch: line low for 4 cycles only
    dv0 = dv_cnt; fe0 = fe_cnt; pe0 = pe_cnt;
    rx_in = 1'b0;
    repeat (4) @(negedge clk);
    rx_in = 1'b1;
    repeat (30) @(negedge clk);
    check("glitch_dv_pulses", 32'(dv_cnt - dv0), 32'd0);
    check("glitch_fe_pulses", 32'(fe_cnt - fe0), 32'd0);
    check("glitch_data_out", 32'(data_out), 32'hA5);
    check("glitch_busy", 32'(rx_busy), 32'h0);

    // Frame 8'h3C with a low stop bit; the line stays low for 40 cycles
    dv0 = dv_cnt; fe0 = fe_cnt; pe0 = pe_cnt;
    send_frame(8'h3C, ^8'h3C, 1'b0, 40);
    check("ferr_fe_pulses", 32'(fe_cnt - fe0), 32'd1);
    check("ferr_dv_pulses", 32'(dv_cnt - dv0), 32'd0);
    check("ferr_data_out", 32'(data_out), 32'hA5);
    check("ferr_busy_while_low", 32'(rx_busy), 32'h1);
    rx_in = 1'b1;
    repeat (6) @(negedge clk);
    check("ferr_busy_after_high", 32'(rx_busy), 32'h0);
    repeat (10) @(negedge clk);

    // Back-to-back frames 8'h00 then 8'hFF
    dv0 = dv_cnt;
    send_frame(8'h00, ^8'h00, 1'b1, CPB);
    send_frame(8'hFF, ^8'hFF, 1'b1, CPB);
    rx_in = 1'b1;
    repeat (4) @(negedge clk);
    check("b2b_dv_pulses", 32'(dv_cnt - dv0), 32'd2);
    check("b2b_first_byte", 32'(prev_data), 32'h00);
    check("b2b_second_byte", 32'(last_data), 32'hFF);
    check("b2b_data_out", 32'(data_out), 32'hFF);

    // Reset in the middle of bit 4 of 8'h55, then frame 8'h81
    dv0 = dv_cnt;
    rx_in = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx_in = ((8'h55 >> i) & 8'h01) != 8'h00;
      repeat (CPB) @(negedge clk);
    end
    rx_in = 1'b1;
    repeat (CPB / 2) @(negedge clk);
    reset = 1'b0;
    #1;
    check("midrst_data_out", 32'(data_out), 32'h00);
    check("midrst_busy", 32'(rx_busy), 32'h0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (24) @(negedge clk);
    check("midrst_no_dv", 32'(dv_cnt - dv0), 32'd0);
    check("midrst_data_between", 32'(data_out), 32'h00);
    send_frame(8'h81, ^8'h81, 1'b1, CPB);
    rx_in = 1'b1;
    repeat (4) @(negedge clk);
    check("midrst_dv_pulses", 32'(dv_cnt - dv0), 32'd1);
    check("midrst_data_out_81", 32'(data_out), 32'h81);

`ifdef RX_PARITY_EN
    // 8'h07 has three ones, so the even-parity bit must be 1
    dv0 = dv_cnt; pe0 = pe_cnt;
    send_frame(8'h07, 1'b0, 1'b1, CPB);
    rx_in = 1'b1;
    repeat (4) @(negedge clk);
    check("par_bad_pe_pulses", 32'(pe_cnt - pe0), 32'd1);
    check("par_bad_dv_pulses", 32'(dv_cnt - dv0), 32'd0);
    check("par_bad_data_out", 32'(data_out), 32'h81);
    dv0 = dv_cnt; pe0 = pe_cnt;
    send_frame(8'h07, 1'b1, 1'b1, CPB);
    rx_in = 1'b1;
    repeat (4) @(negedge clk);
    check("par_ok_pe_pulses", 32'(pe_cnt - pe0), 32'd0);
    check("par_ok_dv_pulses", 32'(dv_cnt - dv0), 32'd1);
    check("par_ok_data_out", 32'(data_out), 32'h07);
`endif

    check("pulse_exclusive", 32'(viol), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/rx_serial_receiver.md
RX_SERIAL_RECEIVER -- requirements
Module: rx_serial_receiver

Interface
REQ-001 Parameter CLKS_PER_BIT, default 5208, clock cycles per serial bit; legal range 4..65535.
REQ-002 clk  input  1  system clock; all state changes occur on its rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 rx_in  input  1  serial line, idle high, asynchronous to clk.
REQ-005 data_out  output  8  last correctly received byte.
REQ-006 data_valid  output  1  one-cycle pulse when data_out is updated.
REQ-007 framing_error  output  1  one-cycle pulse when a stop bit samples low.
REQ-008 rx_busy  output  1  high whenever the state machine is not in IDLE.
REQ-009 parity_error  output  1  one-cycle parity failure pulse; present only with RX_PARITY_EN.

Function
REQ-010 rx_in SHALL pass through a 2-flop synchronizer; all logic uses the second flop output (rx_s).
REQ-011 States SHALL be IDLE, START, DATA, PARITY (RX_PARITY_EN only), STOP, WAIT_HIGH.
REQ-012 IDLE: rx_s low SHALL move to START with bit counter cleared.
REQ-013 START: at count CLKS_PER_BIT/2-1 (integer division), rx_s low -> DATA with counter cleared; rx_s high -> IDLE (glitch rejected, no outputs).
REQ-014 DATA: rx_s SHALL be sampled at every count CLKS_PER_BIT-1, 8 samples, LSB first, into a shift register.
REQ-015 After the 8th sample, next state SHALL be PARITY if RX_PARITY_EN is defined, else STOP.
REQ-016 STOP: at count CLKS_PER_BIT-1, rx_s high -> data_out loaded and data_valid pulsed next cycle, state IDLE.
REQ-017 STOP sample low -> framing_error pulsed one cycle, data_out unchanged, data_valid low, state WAIT_HIGH.
REQ-018 WAIT_HIGH: remain until rx_s high, then IDLE; no new start bit is accepted while here (break condition).
REQ-019 data_valid, framing_error, parity_error SHALL never be high in the same cycle and never high two consecutive cycles.
REQ-020 Total latency: data_valid rises exactly 2 + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT (+CLKS_PER_BIT with parity) cycles after the rx_in falling edge, +/-1 cycle for synchronizer phase.
REQ-021 Back-to-back frames (next start bit immediately after stop) SHALL be received without loss.
REQ-022 Counter width SHALL be 16 bits; counter never wraps mid-bit.

Reset
REQ-023 reset low SHALL immediately force state IDLE, counters 0, shift register 0, data_out 8'h00, all pulse outputs 0, rx_busy 0, synchronizer flops 1.
REQ-024 reset asserted mid-frame SHALL discard the partial byte; after release, reception restarts at the next falling edge on rx_s.

Configuration
REQ-025 Macro RX_PARITY_EN defined: PARITY state samples one even-parity bit after DATA; mismatch -> parity_error pulse, data_out unchanged, no data_valid, STOP still checked for framing (framing_error takes precedence and suppresses parity_error).
REQ-026 RX_PARITY_EN undefined: no PARITY state, parity_error port absent, frame is 10 bits.

Verification (CLKS_PER_BIT=16)
REQ-027 Frame 8'hA5, correct stop -> data_out=8'hA5, single data_valid pulse, rx_busy low afterwards.
REQ-028 rx_in low for 4 cycles then high -> START aborts, no pulses, data_out unchanged, returns IDLE.
REQ-029 Frame 8'h3C with stop bit low, line held low 40 cycles -> framing_error pulse, data_out unchanged, rx_busy high until line returns high.
REQ-030 Two frames 8'h00 then 8'hFF back-to-back -> two data_valid pulses, data_out 8'h00 then 8'hFF.
REQ-031 reset pulsed low during bit 4 of 8'h55, then frame 8'h81 -> only 8'h81 reported, data_out 8'h00 between.
REQ-032 RX_PARITY_EN, frame 8'h07 with parity 0 -> parity_error pulse, no data_valid; with parity 1 -> data_valid, data_out=8'h07.
